mmio_port_arbiter: RTL and testbench

- Shares one memory-mapped peripheral port (interrupt controller register bank, timer, etc.) between two requesters: instruction-fetch side (m0) and load/store side (m1).
- Sits between the core and a single slave that uses the active-low enable_ plus read/write-enable/busy handshake.
- Round-robin arbitration, one outstanding transaction, timeout with error response.

---
 rtl/mmio_port_arbiter_pkg.sv | 10 +
 rtl/mmio_port_arbiter_rr_arbiter2.sv | 10 +
 rtl/mmio_port_arbiter.sv | 120 ++++++++++++
 tb/tb_mmio_port_arbiter.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/mmio_port_arbiter_pkg.sv
// mmio_port_arbiter_pkg: memsize codes and FSM state encodings shared by the arbiter
package mmio_port_arbiter_pkg;
    localparam logic [1:0] MS_BYTE  = 2'd0;
    localparam logic [1:0] MS_HALF  = 2'd1;
    localparam logic [1:0] MS_WORD  = 2'd2;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;
endpackage

// File: rtl/mmio_port_arbiter_rr_arbiter2.sv
// rr_arbiter2: combinational two-way round-robin grant, ties go to the requester not served last
module rr_arbiter2 (
    input  logic [1:0] i_req,
    input  logic       i_last,
    output logic       o_grant,
    output logic       o_valid
);
    assign o_grant = &i_req ? ~i_last : i_req[1];
    assign o_valid = |i_req;
endmodule

// File: rtl/mmio_port_arbiter.sv
// mmio_port_arbiter: shares one enable_/busy MMIO slave between fetch (m0) and load/store (m1)
module mmio_port_arbiter
    import mmio_port_arbiter_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 32,
    parameter int TIMEOUT       = 255
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_m0_read_enable,
    input  logic                     i_m0_write_enable,
    input  logic [ADDRESS_WIDTH-1:0] i_m0_address,
    input  logic [31:0]              i_m0_out,
    input  logic [1:0]               i_m0_memsize,
    output logic [31:0]              o_m0_in,
    output logic                     o_m0_busy,
    output logic                     o_m0_done,
    output logic                     o_m0_err,
    input  logic                     i_m1_read_enable,
    input  logic                     i_m1_write_enable,
    input  logic [ADDRESS_WIDTH-1:0] i_m1_address,
    input  logic [31:0]              i_m1_out,
    input  logic [1:0]               i_m1_memsize,
    output logic [31:0]              o_m1_in,
    output logic                     o_m1_busy,
    output logic                     o_m1_done,
    output logic                     o_m1_err,
    output logic                     o_s_enable_,
    output logic [ADDRESS_WIDTH-1:0] o_s_address,
    output logic [31:0]              o_s_out,
    output logic [1:0]               o_s_memsize,
    output logic                     o_s_write_enable,
    output logic                     o_s_read_enable,
    input  logic [31:0]              i_s_in,
    input  logic                     i_s_busy
);
    logic [1:0]               w_req, w_wr;
    logic                     w_gnt, w_valid, w_tmo, w_ok, w_fin, w_live;
    logic [1:0]               r_state, r_busy, r_done, r_err;
    logic                     r_gnt, r_last, r_wr;
    logic [7:0]               r_timer;
    logic [31:0]              r_in [2];
    assign w_req  = {i_m1_read_enable | i_m1_write_enable, i_m0_read_enable | i_m0_write_enable};
    assign w_wr   = {i_m1_write_enable, i_m0_write_enable};
    assign w_tmo  = r_timer == 8'(TIMEOUT - 1);
    assign w_ok   = r_state == ST_WAIT && !i_s_busy;
    assign w_fin  = w_ok || ((r_state == ST_ISSUE || r_state == ST_WAIT) && w_tmo);
    // a master that dropped its request after grant gets no completion pulse
    assign w_live = r_busy[r_gnt] & w_req[r_gnt];
    rr_arbiter2 u_arb (.i_req(w_req), .i_last(r_last), .o_grant(w_gnt), .o_valid(w_valid));
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state          <= ST_IDLE;
            r_busy           <= '0;
            r_done           <= '0;
            r_err            <= '0;
            r_gnt            <= 1'b0;
            r_last           <= 1'b1;
            r_wr             <= 1'b0;
            r_timer          <= '0;
            r_in[0]          <= '0;
            r_in[1]          <= '0;
            o_s_enable_      <= 1'b1;
            o_s_address      <= '0;
            o_s_out          <= '0;
            o_s_memsize      <= '0;
            o_s_write_enable <= 1'b0;
            o_s_read_enable  <= 1'b0;
        end else begin
            r_done <= '0;
            r_err  <= '0;
            case (r_state)
                ST_IDLE: begin
                    r_busy <= w_req;
                    if (w_valid) begin
                        r_state          <= ST_ISSUE;
                        r_gnt            <= w_gnt;
                        r_wr             <= w_wr[w_gnt];
                        r_timer          <= '0;
                        o_s_enable_      <= 1'b0;
                        o_s_address      <= w_gnt ? i_m1_address : i_m0_address;
                        o_s_out          <= w_gnt ? i_m1_out : i_m0_out;
                        o_s_memsize      <= w_gnt ? i_m1_memsize : i_m0_memsize;
                        o_s_write_enable <= w_wr[w_gnt];
                        o_s_read_enable  <= !w_wr[w_gnt];
                    end
                end
                ST_ISSUE, ST_WAIT: begin
                    r_timer         <= r_timer + 8'd1;
                    r_busy[!r_gnt]  <= w_req[!r_gnt];
                    r_busy[r_gnt]   <= w_live & !w_fin;
                    if (w_fin) begin
                        r_state          <= ST_RESP;
                        o_s_enable_      <= 1'b1;
                        o_s_write_enable <= 1'b0;
                        o_s_read_enable  <= 1'b0;
                        r_done[r_gnt]    <= w_live;
                        r_err[r_gnt]     <= w_live & !w_ok;
                        if (w_live && !r_wr)
                            r_in[r_gnt] <= w_ok ? i_s_in : '0;
                    end else if (r_state == ST_ISSUE && i_s_busy)
                        r_state <= ST_WAIT;
                end
                default: begin
                    r_busy  <= w_req;
                    r_last  <= r_gnt;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end
    assign o_m0_in   = r_in[0];
    assign o_m1_in   = r_in[1];
    assign o_m0_busy = r_busy[0];
    assign o_m1_busy = r_busy[1];
    assign o_m0_done = r_done[0];
    assign o_m1_done = r_done[1];
    assign o_m0_err  = r_err[0];
    assign o_m1_err  = r_err[1];
endmodule

// File: tb/tb_mmio_port_arbiter.sv
// tb_mmio_port_arbiter: directed vectors with hand-computed expectations for the MMIO arbiter
module tb_mmio_port_arbiter;
    import mmio_port_arbiter_pkg::*;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        m0_re = 0, m0_we = 0, m1_re = 0, m1_we = 0;
    logic [31:0] m0_addr = 0, m1_addr = 0, m0_wd = 0, m1_wd = 0;
    logic [1:0]  m0_ms = 0, m1_ms = 0;
    logic [31:0] m0_in, m1_in, s_addr, s_wd, s_in = 0;
    logic        m0_busy, m1_busy, m0_done, m1_done, m0_err, m1_err;
    logic        s_en_n, s_we, s_re, s_busy = 0;
    logic [1:0]  s_ms;
    int          errors = 0, checks = 0;
    mmio_port_arbiter #(.ADDRESS_WIDTH(32), .TIMEOUT(8)) dut (
        .i_clk(clk), .i_reset(reset),
        .i_m0_read_enable(m0_re), .i_m0_write_enable(m0_we), .i_m0_address(m0_addr),
        .i_m0_out(m0_wd), .i_m0_memsize(m0_ms), .o_m0_in(m0_in), .o_m0_busy(m0_busy),
        .o_m0_done(m0_done), .o_m0_err(m0_err),
        .i_m1_read_enable(m1_re), .i_m1_write_enable(m1_we), .i_m1_address(m1_addr),
        .i_m1_out(m1_wd), .i_m1_memsize(m1_ms), .o_m1_in(m1_in), .o_m1_busy(m1_busy),
        .o_m1_done(m1_done), .o_m1_err(m1_err),
        .o_s_enable_(s_en_n), .o_s_address(s_addr), .o_s_out(s_wd), .o_s_memsize(s_ms),
        .o_s_write_enable(s_we), .o_s_read_enable(s_re), .i_s_in(s_in), .i_s_busy(s_busy)
    );
    always #5 clk = ~clk;
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    // called in an ISSUE cycle; slave busy one cycle then returns data, leaves bench in RESP
    task automatic xact(input logic [31:0] data);
        s_busy = 1;
        tick;
        s_busy = 0;
        s_in = data;
        tick;
    endtask
    initial begin
        tick;
        tick;
        reset = 0;
        chk("rst_en_n", s_en_n, 1);
        chk("rst_busy", {m0_busy, m1_busy, m0_done, m1_done, m0_err, m1_err}, 0);
        chk("rst_s", {s_addr, s_re, s_we}, 0);
        chk("rst_in", {m0_in, m1_in}, 0);
        // single m0 word read, minimum latency
        m0_re = 1; m0_addr = 32'h10; m0_ms = MS_WORD;
        tick;
        chk("rd_issue", {s_en_n, s_re, s_we, s_ms}, {1'b0, 1'b1, 1'b0, MS_WORD});
        chk("rd_addr", s_addr, 32'h10);
        chk("rd_busy", m0_busy, 1);
        s_busy = 1;
        tick;
        chk("rd_wait", {s_en_n, m0_done}, 0);
        s_busy = 0; s_in = 32'hDEADBEEF;
        tick;
        chk("rd_done", {m0_done, m0_err, m0_busy, s_en_n, s_re}, 5'b10010);
        chk("rd_data", m0_in, 32'hDEADBEEF);
        m0_re = 0;
        tick;
        chk("rd_pulse", m0_done, 0);
        // alternation from reset: m0, m1, m0, m1
        reset = 1;
        tick;
        reset = 0;
        m0_re = 1; m0_addr = 32'h100; m1_re = 1; m1_addr = 32'h200;
        tick;
        chk("alt1_addr", s_addr, 32'h100);
        chk("alt1_busy", {m0_busy, m1_busy}, 2'b11);
        xact(32'h11111111);
        chk("alt1_done", {m0_done, m1_done, m1_busy}, 3'b101);
        m0_re = 0;
        tick;
        chk("alt2_wait", m1_busy, 1);
        tick;
        chk("alt2_addr", s_addr, 32'h200);
        xact(32'h22222222);
        chk("alt2_done", {m0_done, m1_done}, 2'b01);
        chk("alt2_data", {m0_in, m1_in}, {32'h11111111, 32'h22222222});
        m0_re = 1;
        tick;
        tick;
        chk("alt3_addr", s_addr, 32'h100);
        xact(32'h33330000);
        chk("alt3_done", {m0_done, m1_done}, 2'b10);
        tick;
        tick;
        chk("alt4_addr", s_addr, 32'h200);
        xact(32'h44440000);
        chk("alt4_done", {m0_done, m1_done, m1_in}, {2'b01, 32'h44440000});
        m0_re = 0; m1_re = 0;
        tick;
        // m1 byte write, requester inputs ignored after latch
        m1_we = 1; m1_addr = 32'h5; m1_wd = 32'hAB000000; m1_ms = MS_BYTE;
        tick;
        chk("wr_issue", {s_en_n, s_we, s_re, s_ms}, {1'b0, 1'b1, 1'b0, MS_BYTE});
        chk("wr_bus", {s_addr, s_wd}, {32'h5, 32'hAB000000});
        m1_addr = 32'h99; m1_wd = 32'h0; m1_ms = MS_HALF;
        s_busy = 1; s_in = 32'h5555;
        tick;
        chk("wr_hold", {s_we, s_addr, s_wd, s_ms}, {1'b1, 32'h5, 32'hAB000000, MS_BYTE});
        s_busy = 0;
        tick;
        chk("wr_done", {m1_done, m1_err, s_we, s_en_n}, 4'b1001);
        chk("wr_in", m1_in, 32'h44440000);
        m1_we = 0;
        tick;
        // slave never responds, timeout after 8 issue cycles
        m0_re = 1; m0_addr = 32'h40; s_in = 32'hFFFFFFFF;
        tick;
        for (int i = 0; i < 7; i++) tick;
        chk("to_pend", {m0_done, s_en_n}, 0);
        tick;
        chk("to_done", {m0_done, m0_err, s_en_n}, 3'b111);
        chk("to_data", m0_in, 0);
        m0_re = 0;
        tick;
        chk("to_clr", {m0_done, m0_err}, 0);
        // reset during WAIT of an m1 transaction
        m0_re = 1; m0_addr = 32'h400; m1_re = 1; m1_addr = 32'h500;
        tick;
        chk("rw_addr", s_addr, 32'h500);
        s_busy = 1;
        tick;
        reset = 1;
        tick;
        reset = 0; s_busy = 0;
        chk("rw_rst", {s_en_n, m0_busy, m1_busy, m1_done, s_re}, 5'b10000);
        tick;
        chk("rw_prio", s_addr, 32'h400);
        chk("rw_nodone", m1_done, 0);
        xact(32'h55555555);
        chk("rw_done", {m0_done, m0_in}, {1'b1, 32'h55555555});
        m0_re = 0; m1_re = 0;
        tick;
        // m0 withdraws after grant, then m1 served normally
        m0_re = 1; m0_addr = 32'h80;
        tick;
        m0_re = 0; m1_re = 1; m1_addr = 32'h300;
        s_busy = 1;
        tick;
        chk("wd_busy", {m0_busy, m1_busy}, 2'b01);
        s_busy = 0; s_in = 32'h77777777;
        tick;
        chk("wd_nodone", {m0_done, m0_err, s_en_n}, 3'b001);
        chk("wd_in", m0_in, 32'h55555555);
        tick;
        tick;
        chk("wd_m1addr", s_addr, 32'h300);
        xact(32'h33333333);
        chk("wd_m1done", {m1_done, m0_done, m1_in}, {2'b10, 32'h33333333});
        m1_re = 0;
        tick;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
